// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared state encoding and constants for the fetch stage
package inst_fetch_pkg;
  typedef enum logic {IF_QUERY = 1'b0, IF_FETCH = 1'b1} if_state_t;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: PC holder that queries inst_cache and refills it byte-wise from memory on a miss
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              stall_i,
  output logic              cache_query_o,
  output logic [ADDR_W-1:0] query_addr_o,
  input  logic              inst_hit_i,
  input  logic [31:0]       inst_cache_i,
  output logic              cache_enable_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [31:0]       cache_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [7:0]        mem_byte_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o
);
  if_state_t state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [1:0] cnt;
  logic [23:0] fill_buf;
  logic active, last_byte;
  assign active = !rst && rdy;
  assign last_byte = mem_valid_i && cnt == 2'd3;
  assign cache_query_o = active && state == IF_QUERY;
  assign mem_req_o = active && state == IF_FETCH;
  // the final byte bypasses the buffer so the write lands in the same cycle it arrives
  assign cache_enable_o = mem_req_o && last_byte;
  assign cache_data_o = {mem_byte_i, fill_buf};
  assign query_addr_o = pc;
  assign cache_addr_o = pc;
  assign mem_addr_o = pc + ADDR_W'(cnt);
  always_comb begin
    state_next = branch_flag_i ? IF_QUERY :
                 state == IF_QUERY ? (inst_hit_i ? IF_QUERY : IF_FETCH) :
                 last_byte ? IF_QUERY : IF_FETCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_QUERY;
      pc <= RESET_PC;
      cnt <= 2'd0;
      fill_buf <= '0;
      if_pc_o <= '0;
      if_inst_o <= ZERO_WORD;
      if_valid_o <= 1'b0;
    end else if (rdy) begin
      state <= state_next;
      if (branch_flag_i) begin
        pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
        cnt <= 2'd0;
        if_valid_o <= 1'b0;
      end else if (state == IF_QUERY) begin
        cnt <= 2'd0;
        if (inst_hit_i && !stall_i) begin
          if_inst_o <= inst_cache_i;
          if_pc_o <= pc;
          if_valid_o <= 1'b1;
          pc <= pc + ADDR_W'(4);
        end else if (!inst_hit_i && !stall_i) begin
          if_valid_o <= 1'b0;
        end
      end else begin
        if (!stall_i) if_valid_o <= 1'b0;
        if (mem_valid_i) cnt <= cnt + 2'd1;
        if (mem_valid_i && cnt != 2'd3) fill_buf[{cnt, 3'b000} +: 8] <= mem_byte_i;
      end
    end
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of inst_cache.
- Holds the PC and queries the cache every cycle it is able to advance. A hit delivers a 32-bit instruction to the IF/ID boundary.
- On a miss it reads four bytes from the byte-wide memory controller (little-endian), assembles the word, writes it into inst_cache, then re-queries.
- Accepts branch redirects from downstream and a downstream stall.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
ADDR_W, 32, PC/address width; matches `InstAddrBus.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset (`RstEnable = 1)
rdy  in  1  global ready; 0 freezes all state
branch_flag_i  in  1  redirect request
branch_target_i  in  32  redirect PC; bits [1:0] forced to 00
stall_i  in  1  downstream cannot accept a new instruction
cache_query_o  out  1  query strobe to inst_cache
query_addr_o  out  32  = pc
inst_hit_i  in  1  cache hit (combinational response)
inst_cache_i  in  32  cached instruction
cache_enable_o  out  1  one-cycle cache write strobe
cache_addr_o  out  32  = pc
cache_data_o  out  32  assembled word
mem_req_o  out  1  byte-read request to memory controller
mem_addr_o  out  32  byte address = pc + cnt
mem_valid_i  in  1  mem_byte_i valid for the current mem_addr_o
mem_byte_i  in  8  returned byte
if_pc_o  out  32  PC of the delivered instruction (registered)
if_inst_o  out  32  delivered instruction (registered)
if_valid_o  out  1  delivered instruction valid (registered)

Behaviour:
- Priority order at each posedge clk: rst > (rdy==0: hold everything) > branch_flag_i > stall/fetch logic.
- Reset values:
  - pc=RESET_PC, state=QUERY, cnt=0, buf=0.
  - if_pc_o=0, if_inst_o=`ZeroWord, if_valid_o=0.
- Combinational outputs are 0 while rst=1 or rdy=0.
- State QUERY:
  - cache_query_o=1, mem_req_o=0.
  - Hit and !stall_i: if_inst_o<=inst_cache_i, if_pc_o<=pc, if_valid_o<=1, pc<=pc+4. This gives one instruction per cycle on consecutive hits.
  - Hit and stall_i: hold pc and all if_* outputs.
  - Miss, regardless of stall_i: state<=FETCH, cnt<=0. If !stall_i, if_valid_o<=0; otherwise hold.
- State FETCH:
  - cache_query_o=0, mem_req_o=1, mem_addr_o=pc+cnt. cnt is 2 bits.
  - On mem_valid_i: buf[8*cnt +: 8]<=mem_byte_i, cnt<=cnt+1.
  - Gaps (mem_valid_i=0) are allowed; state holds.
  - cnt==3 and mem_valid_i: cache_enable_o=1 (combinational, that cycle only). cache_data_o={mem_byte_i, buf[23:0]}. state<=QUERY.
  - The next cycle's query then hits.
  - If !stall_i, if_valid_o<=0 on every FETCH cycle (bubble); otherwise hold.
- Miss latency with back-to-back bytes:
  - query-miss cycle T0; bytes at T1..T4; cache write at the T4 edge; hit at T5.
  - if_valid_o rises after the T5 edge.
- Branch (branch_flag_i=1):
  - pc<={branch_target_i[31:2],2'b00}, if_valid_o<=0, state<=QUERY, cnt<=0.
  - Overrides stall_i.
  - An in-flight FETCH is abandoned; mem_req_o drops the next cycle.
  - If the branch coincides with the final byte, the cache write still occurs, because the data is correct for the old pc.
- Wrap-around: pc+4 and pc+cnt wrap modulo 2^32.
- rst mid-FETCH: fill abandoned, no cache write, mem_req_o=0 from that cycle.
- cache_addr_o/query_addr_o always equal pc. cache_enable_o is never 1 outside FETCH.

Decomposition:
- defines.v additions: IfQuery/IfFetch state encodings.
- Reuse `ZeroWord, `RstEnable, `InstAddrBus, `InstBus.
- No sub-module: the byte assembler is ~10 lines inline. inst_cache and inst_fetch are instantiated side by side in the CPU top.

Test Plan:
- Reset, with RESET_PC=0 and the cache preloaded at 0x0/0x4 -> if_valid_o=1 on the 1st and 2nd cycles after reset release; if_pc_o=0x0 then 0x4.
- Cold miss at pc=0x100, memory bytes 13,05,00,00 returned one per cycle -> cache_enable_o at T4 with cache_data_o=0x00000513; if_inst_o=0x00000513, if_pc_o=0x100 after T5.
- Miss with mem_valid_i gaps (valid on cycles 1,3,4,7) -> bytes placed in order; exactly one cache_enable_o pulse; correct word.
- stall_i=1 during a hit at pc=0x8 for 3 cycles -> if_* held, pc stays 0x8; advances to 0xC the cycle after stall_i falls.
- branch_flag_i=1 with target 0x203 at FETCH cnt=2 -> mem_req_o=0 next cycle, pc=0x200, if_valid_o=0, no cache write, query at 0x200.
- rdy=0 for 4 cycles mid-FETCH -> cnt/buf/pc frozen; fill resumes correctly when rdy=1.
